// File: rtl/aes_pkg.sv
// Shared types for the AES core arbiter: key-size modes, arbiter states and
// the latched per-grant core configuration.
package aes_pkg;
    typedef enum logic [1:0] {
        AES128 = 2'b00,
        AES192 = 2'b01,
        AES256 = 2'b10
    } aes_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        BUSY  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;

    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef struct packed {
        logic [1:0] mode;
        logic       enc_dec;
    } core_cfg_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// walking cyclically, returned as one-hot grant plus index.
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = ptr;
        for (int i = 0; i < N; i++) begin
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
            // ptr is always < N, so explicit wrap keeps non-power-of-two N correct
            j = (j == IW'(N - 1)) ? '0 : j + 1'b1;
        end
    end
endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one AES round core between NUM_REQ requesters, with a
// watchdog that aborts a stuck core and reports the error to the winner.
module aes_core_arbiter
    import aes_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int TIMEOUT_CYC = 48,
    localparam int IW          = $clog2(NUM_REQ),
    localparam int WW          = $clog2(TIMEOUT_CYC) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0][1:0] req_mode,
    input  logic [NUM_REQ-1:0]      req_enc_dec,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    core_start,
    output logic [1:0]              core_mode,
    output logic                    core_enc_dec,
    output logic                    core_flush,
    input  logic                    core_done,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic                    rsp_err,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic                    busy,
    output logic [IW-1:0]           grant_id
);
    arb_state_t         state;
    logic [IW-1:0]      rr_ptr;
    logic [WW-1:0]      wd_cnt;
    logic               err_q;
    core_cfg_t          cfg_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               hs;
    logic               wd_last;

    rr_picker #(.N(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // grant is drawn only from set req_valid bits, so any grant is a handshake
    assign hs      = (state == IDLE) && pick_any;
    assign wd_last = (wd_cnt == WW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            wd_cnt   <= '0;
            err_q    <= 1'b0;
            cfg_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        grant_id      <= pick_idx;
                        cfg_q.mode    <= req_mode[pick_idx];
                        cfg_q.enc_dec <= req_enc_dec[pick_idx];
                        rr_ptr        <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        // illegal key size bypasses the core entirely
                        if (req_mode[pick_idx] == MODE_ILLEGAL) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= BUSY;
                end
                BUSY: begin
                    if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
                    if (core_done) begin
                        err_q <= 1'b0;
                        state <= RESP;
                    end else if (wd_last) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_id]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state == IDLE) ? pick_gnt : '0;
    assign core_start   = (state == ISSUE);
    assign core_flush   = (state == BUSY) && !core_done && wd_last;
    assign core_mode    = cfg_q.mode;
    assign core_enc_dec = cfg_q.enc_dec;
    assign rsp_err      = (state == RESP) && err_q;
    assign busy         = (state != IDLE);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
        assign rsp_valid[i] = (state == RESP) && (grant_id == IW'(i));
    end
endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter: single request, fairness, illegal mode,
// watchdog timeout, response backpressure and reset mid-operation.
module tb_aes_core_arbiter;
    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req_valid;
    logic [3:0][1:0] req_mode;
    logic [3:0]      req_enc_dec;
    logic [3:0]      req_ready;
    logic            core_start;
    logic [1:0]      core_mode;
    logic            core_enc_dec;
    logic            core_flush;
    logic            core_done;
    logic [3:0]      rsp_valid;
    logic            rsp_err;
    logic [3:0]      rsp_ready;
    logic            busy;
    logic [1:0]      grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_core_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(48)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_mode     (req_mode),
        .req_enc_dec  (req_enc_dec),
        .req_ready    (req_ready),
        .core_start   (core_start),
        .core_mode    (core_mode),
        .core_enc_dec (core_enc_dec),
        .core_flush   (core_flush),
        .core_done    (core_done),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_ready    (rsp_ready),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one cycle; inputs changed afterwards settle before the #1 check point
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic flush_seen;
        reset = 1'b0; req_valid = '0; req_mode = '0; req_enc_dec = '0;
        core_done = 1'b0; rsp_ready = '0;
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_core_mode", 32'(core_mode), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        reset = 1'b1;
        step();

        // single request, core done 12 cycles after handshake
        req_valid = 4'b0001; #1;
        chk("t1_req_ready", 32'(req_ready), 32'b0001);
        step(); req_valid = '0; #1;
        chk("t1_start", 32'(core_start), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready_off", 32'(req_ready), 32'd0);
        step();
        chk("t1_start_once", 32'(core_start), 32'd0);
        for (int i = 0; i < 10; i++) step();
        core_done = 1'b1; #1;
        chk("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
        step(); core_done = 1'b0; #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("t1_rsp_err", 32'(rsp_err), 32'd0);
        rsp_ready = 4'b0001;
        step(); rsp_ready = '0; #1;
        chk("t1_idle", 32'(busy), 32'd0);

        // fairness from a fresh pointer
        reset = 1'b0; step(); reset = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t2_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            step(); step();
            core_done = 1'b1;
            step(); core_done = 1'b0; rsp_ready = 4'b1111; #1;
            chk("t2_rsp", 32'(rsp_valid), 32'(4'b0001 << (k % 4)));
            chk("t2_gid", 32'(grant_id), 32'(k % 4));
            step(); rsp_ready = '0;
        end
        req_valid = '0;

        // illegal mode on requester 2 (pointer now at 1)
        req_valid = 4'b0100; req_mode[2] = 2'b11; #1;
        chk("t3_ready", 32'(req_ready), 32'b0100);
        step(); req_valid = '0; #1;
        chk("t3_rsp_valid", 32'(rsp_valid), 32'b0100);
        chk("t3_rsp_err", 32'(rsp_err), 32'd1);
        chk("t3_no_start", 32'(core_start), 32'd0);
        rsp_ready = 4'b0100;
        step(); rsp_ready = '0; req_mode[2] = 2'b00;
        req_valid = 4'b1111; #1;
        chk("t3_next_grant", 32'(req_ready), 32'b1000);

        // backpressure on requester 3's response
        step(); step(); core_done = 1'b1;
        step(); core_done = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_rsp_hold", 32'(rsp_valid), 32'b1000);
            chk("t5_ready_off", 32'(req_ready), 32'd0);
            chk("t5_no_start", 32'(core_start), 32'd0);
            step(); #1;
        end
        rsp_ready = 4'b0111;
        step(); #1;
        chk("t5_other_ready", 32'(rsp_valid), 32'b1000);
        rsp_ready = 4'b1000;
        step(); rsp_ready = '0; req_valid = '0; #1;
        chk("t5_released", 32'(busy), 32'd0);

        // watchdog timeout, AES192 decrypt on requester 0
        req_valid = 4'b0001; req_mode[0] = 2'b01; req_enc_dec[0] = 1'b1; #1;
        chk("t4_ready", 32'(req_ready), 32'b0001);
        step(); req_valid = '0; #1;
        chk("t4_mode", 32'(core_mode), 32'b01);
        chk("t4_dir", 32'(core_enc_dec), 32'd1);
        step();
        flush_seen = 1'b0;
        for (int i = 0; i < 47; i++) begin
            flush_seen |= core_flush;
            step();
        end
        chk("t4_no_early_flush", 32'(flush_seen), 32'd0);
        chk("t4_flush", 32'(core_flush), 32'd1);
        chk("t4_rsp_not_yet", 32'(rsp_valid), 32'd0);
        step();
        chk("t4_flush_once", 32'(core_flush), 32'd0);
        chk("t4_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("t4_rsp_err", 32'(rsp_err), 32'd1);
        core_done = 1'b1;
        step(); core_done = 1'b0; #1;
        chk("t4_late_done_rsp", 32'(rsp_valid), 32'b0001);
        chk("t4_late_done_err", 32'(rsp_err), 32'd1);
        chk("t4_late_done_start", 32'(core_start), 32'd0);
        rsp_ready = 4'b0001;
        step(); rsp_ready = '0;
        req_mode[0] = 2'b00; req_enc_dec[0] = 1'b0;

        // reset while BUSY on requester 1
        req_valid = 4'b0010; #1;
        chk("t6_ready", 32'(req_ready), 32'b0010);
        step(); req_valid = '0;
        step(); step();
        reset = 1'b0;
        step(); #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_flush", 32'(core_flush), 32'd0);
        chk("t6_grant_id", 32'(grant_id), 32'd0);
        chk("t6_core_mode", 32'(core_mode), 32'd0);
        reset = 1'b1;
        req_valid = 4'b1111; #1;
        chk("t6_fresh_grant", 32'(req_ready), 32'b0001);
        step(); req_valid = '0; #1;
        chk("t6_fresh_gid", 32'(grant_id), 32'd0);
        chk("t6_fresh_start", 32'(core_start), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
